mul5_arbiter: RTL and testbench

//  Shares one 5x5 unsigned array multiplier (mul5) between four requesters.
//  A round-robin arbiter grants one requester, latches its operands, drives
//  mul5 for one cycle, then holds the registered 10-bit product and the

---
 rtl/mul5_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mul5_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul5_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mul5 / mul5_arbiter
//  Purpose  : Four-requester round-robin front end sharing a single 5x5
//             unsigned array multiplier; one operation in flight, result
//             held until the consumer accepts it.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  mul5 : 6x6 unsigned shift-and-add array multiplier. Bit 5 of each input is
//  tied low by the caller, so the low 10 bits carry the exact 5x5 product.
//  Accumulators are P_W bits wide; addition modulo 2^P_W keeps the low bits
//  exact, so truncating each partial product loses nothing that survives.
// ----------------------------------------------------------------------------
module mul5 #(
   parameter int P_W = 12
) (
   input  logic [5:0]     a,
   input  logic [5:0]     b,
   output logic [P_W-1:0] p
);

   logic [P_W-1:0] w_acc [0:6];

   assign w_acc[0] = '0;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_row
         logic [P_W-1:0] w_pp;
         assign w_pp          = P_W'(a & {6{b[gi]}}) << gi;
         assign w_acc[gi + 1] = w_acc[gi] + w_pp;
      end
   endgenerate

   assign p = w_acc[6];

endmodule

// ----------------------------------------------------------------------------
//  mul5_arbiter : IDLE grants one requester and latches its operands,
//  CALC drives mul5 from the latched operands and registers the product,
//  DONE holds the result until res_ready.
// ----------------------------------------------------------------------------
module mul5_arbiter #(
   parameter int N_REQ = 4,
   parameter int OP_W  = 5,
   parameter int P_W   = 10,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*OP_W-1:0] a_in,
   input  logic [N_REQ*OP_W-1:0] b_in,
   output logic [N_REQ-1:0]      gnt,
   output logic                  busy,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [P_W-1:0]        res_p,
   output logic [1:0]            res_id,
   output logic [CNT_W-1:0]      done_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [1:0]       r_rr_ptr;
   logic [OP_W-1:0]  r_op_a;
   logic [OP_W-1:0]  r_op_b;
   logic [1:0]       r_id;
   logic             r_res_valid;
   logic [P_W-1:0]   r_res_p;
   logic [1:0]       r_res_id;
   logic [CNT_W-1:0] r_done_cnt;

   logic             w_found;
   logic [1:0]       w_winner;
   logic [P_W-1:0]   w_prod;
   logic             w_accept;

   // Round-robin pick: first asserted request scanning from r_rr_ptr upward, mod 4.
   always_comb begin
      logic [1:0] idx;
      w_found  = 1'b0;
      w_winner = r_rr_ptr;
      idx      = r_rr_ptr;
      for (int k = 0; k < N_REQ; k++) begin
         idx = r_rr_ptr + 2'(k);
         if (!w_found && req[idx]) begin
            w_found  = 1'b1;
            w_winner = idx;
         end
      end
   end

   assign w_accept = (r_state == S_DONE) && res_ready;

   // Shared multiplier, fed only from latched operands so the requester may move on.
   mul5 #(
      .P_W (P_W)
   ) u_mul5 (
      .a ({1'b0, r_op_a}),
      .b ({1'b0, r_op_b}),
      .p (w_prod)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_found) w_next_state = S_CALC;
         S_CALC:  w_next_state = S_DONE;
         S_DONE:  if (res_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs: grant is a one-cycle combinational pulse in IDLE, held off in reset.
   always_comb begin
      gnt  = '0;
      busy = (r_state != S_IDLE);
      if (rst_n && (r_state == S_IDLE) && w_found) begin
         gnt[w_winner] = 1'b1;
      end
   end

   // Datapath: operand capture on grant, product capture in CALC, acceptance count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= 2'd0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_id        <= 2'd0;
         r_res_valid <= 1'b0;
         r_res_p     <= '0;
         r_res_id    <= 2'd0;
         r_done_cnt  <= '0;
      end else begin
         if ((r_state == S_IDLE) && w_found) begin
            r_op_a   <= a_in[w_winner*OP_W +: OP_W];
            r_op_b   <= b_in[w_winner*OP_W +: OP_W];
            r_id     <= w_winner;
            r_rr_ptr <= w_winner + 2'd1;
         end
         if (r_state == S_CALC) begin
            r_res_p     <= w_prod;
            r_res_id    <= r_id;
            r_res_valid <= 1'b1;
         end
         if (w_accept) begin
            r_res_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + 1'b1;
         end
      end
   end

   assign res_valid = r_res_valid;
   assign res_p     = r_res_p;
   assign res_id    = r_res_id;
   assign done_cnt  = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mul5_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul5_arbiter
//  Purpose  : Self-checking bench for mul5_arbiter: cycle table plus directed
//             sequences for backpressure, mid-operation reset and an
//             exhaustive operand sweep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul5_arbiter;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [19:0] a;
      logic [19:0] b;
      logic        ready;
      logic [3:0]  gnt;
      logic        busy;
      logic        valid;
      logic [9:0]  p;
      logic [1:0]  id;
      logic [7:0]  cnt;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [19:0] a_in;
   logic [19:0] b_in;
   logic [3:0]  gnt;
   logic        busy;
   logic        res_valid;
   logic        res_ready;
   logic [9:0]  res_p;
   logic [1:0]  res_id;
   logic [7:0]  done_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t tbl[$];

   mul5_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_p     (res_p),
      .res_id    (res_id),
      .done_cnt  (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [3:0] rq, input logic [19:0] a,
                      input logic [19:0] b, input logic rdy, input logic [3:0] g,
                      input logic bs, input logic v, input logic [9:0] p,
                      input logic [1:0] id, input logic [7:0] cnt);
      vec_t t;
      t.rst = rst; t.req = rq; t.a = a; t.b = b; t.ready = rdy;
      t.gnt = g; t.busy = bs; t.valid = v; t.p = p; t.id = id; t.cnt = cnt;
      tbl.push_back(t);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      req   = 4'd0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [19:0] a3, b3;
      int w;
      int k;

      rst_n = 1'b0; req = 4'd0; a_in = '0; b_in = '0; res_ready = 1'b1;

      // ---- reset held with random requests
      for (int i = 0; i < 3; i++) begin
         req  = 4'($urandom_range(1, 15));
         a_in = 20'($urandom);
         b_in = 20'($urandom);
         #1;
         chk("rst gnt", 32'(gnt), 0);
         if (i == 0) begin
            chk("rst res_valid", 32'(res_valid), 0);
            chk("rst res_p", 32'(res_p), 0);
            chk("rst done_cnt", 32'(done_cnt), 0);
            chk("rst busy", 32'(busy), 0);
         end
         tick();
      end
      req = 4'd0;
      #2;
      rst_n = 1'b1;
      tick();

      // ---- single op 31*31 on requester 0
      add(0, 4'b0001, 20'd31, 20'd31, 1, 4'b0001, 0, 0, 10'd0,   2'd0, 8'd0);
      add(0, 4'b0000, 20'd31, 20'd31, 1, 4'b0000, 1, 0, 10'd0,   2'd0, 8'd0);
      add(0, 4'b0000, 20'd31, 20'd31, 1, 4'b0000, 1, 1, 10'd961, 2'd0, 8'd0);
      add(0, 4'b0000, 20'd31, 20'd31, 1, 4'b0000, 0, 0, 10'd961, 2'd0, 8'd1);
      // ---- all four requesting from reset: rotation 0,1,2,3
      a3 = {5'd6, 5'd5, 5'd4, 5'd3};
      b3 = {5'd10, 5'd9, 5'd8, 5'd7};
      add(1, 4'b1111, a3, b3, 1, 4'b0001, 0, 0, 10'd0,  2'd0, 8'd0);
      add(0, 4'b1111, a3, b3, 1, 4'b0000, 1, 0, 10'd0,  2'd0, 8'd0);
      add(0, 4'b1111, a3, b3, 1, 4'b0000, 1, 1, 10'd21, 2'd0, 8'd0);
      add(0, 4'b1111, a3, b3, 1, 4'b0010, 0, 0, 10'd21, 2'd0, 8'd1);
      add(0, 4'b1111, a3, b3, 1, 4'b0000, 1, 0, 10'd21, 2'd0, 8'd1);
      add(0, 4'b1111, a3, b3, 1, 4'b0000, 1, 1, 10'd32, 2'd1, 8'd1);
      add(0, 4'b1111, a3, b3, 1, 4'b0100, 0, 0, 10'd32, 2'd1, 8'd2);
      add(0, 4'b1111, a3, b3, 1, 4'b0000, 1, 0, 10'd32, 2'd1, 8'd2);
      add(0, 4'b1111, a3, b3, 1, 4'b0000, 1, 1, 10'd45, 2'd2, 8'd2);
      add(0, 4'b1111, a3, b3, 1, 4'b1000, 0, 0, 10'd45, 2'd2, 8'd3);
      add(0, 4'b1111, a3, b3, 1, 4'b0000, 1, 0, 10'd45, 2'd2, 8'd3);
      add(0, 4'b1111, a3, b3, 1, 4'b0000, 1, 1, 10'd60, 2'd3, 8'd3);
      add(0, 4'b0000, a3, b3, 1, 4'b0000, 0, 0, 10'd60, 2'd3, 8'd4);
      // ---- sparse requests: pointer 0 picks 1, then pointer 2 wraps to 3
      add(0, 4'b1010, a3, b3, 1, 4'b0010, 0, 0, 10'd60, 2'd3, 8'd4);
      add(0, 4'b0000, a3, b3, 1, 4'b0000, 1, 0, 10'd60, 2'd3, 8'd4);
      add(0, 4'b0000, a3, b3, 0, 4'b0000, 1, 1, 10'd32, 2'd1, 8'd4);
      add(0, 4'b0000, a3, b3, 1, 4'b0000, 1, 1, 10'd32, 2'd1, 8'd4);
      add(0, 4'b1010, a3, b3, 1, 4'b1000, 0, 0, 10'd32, 2'd1, 8'd5);
      add(0, 4'b0000, a3, b3, 1, 4'b0000, 1, 0, 10'd32, 2'd1, 8'd5);
      add(0, 4'b0000, a3, b3, 1, 4'b0000, 1, 1, 10'd60, 2'd3, 8'd5);
      add(0, 4'b0000, a3, b3, 1, 4'b0000, 0, 0, 10'd60, 2'd3, 8'd6);

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         req = tbl[i].req; a_in = tbl[i].a; b_in = tbl[i].b; res_ready = tbl[i].ready;
         #1;
         chk($sformatf("row%0d gnt", i),   32'(gnt),       32'(tbl[i].gnt));
         chk($sformatf("row%0d busy", i),  32'(busy),      32'(tbl[i].busy));
         chk($sformatf("row%0d valid", i), 32'(res_valid), 32'(tbl[i].valid));
         chk($sformatf("row%0d res_p", i), 32'(res_p),     32'(tbl[i].p));
         chk($sformatf("row%0d res_id", i), 32'(res_id),   32'(tbl[i].id));
         chk($sformatf("row%0d cnt", i),   32'(done_cnt),  32'(tbl[i].cnt));
         tick();
      end

      // ---- backpressure with requester 1 pending
      do_reset();
      req = 4'b0001; a_in = 20'd9; b_in = 20'd9; res_ready = 1'b0;
      #1;
      chk("bp gnt0", 32'(gnt), 32'b0001);
      tick();
      req  = 4'b0010;
      a_in = {5'd0, 5'd0, 5'd2, 5'd9};
      b_in = {5'd0, 5'd0, 5'd3, 5'd9};
      chk("bp calc gnt", 32'(gnt), 0);
      chk("bp calc busy", 32'(busy), 1);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp hold valid", 32'(res_valid), 1);
         chk("bp hold res_p", 32'(res_p), 81);
         chk("bp hold res_id", 32'(res_id), 0);
         chk("bp hold gnt", 32'(gnt), 0);
         chk("bp hold busy", 32'(busy), 1);
         tick();
      end
      res_ready = 1'b1;
      #1;
      chk("bp release valid", 32'(res_valid), 1);
      tick();
      chk("bp idle busy", 32'(busy), 0);
      chk("bp idle valid", 32'(res_valid), 0);
      chk("bp idle cnt", 32'(done_cnt), 1);
      chk("bp next gnt", 32'(gnt), 32'b0010);
      tick();
      req = 4'd0;
      tick();
      chk("bp second res_p", 32'(res_p), 6);
      chk("bp second res_id", 32'(res_id), 1);
      tick();
      // res_ready with nothing valid must not count
      tick();
      tick();
      chk("ready idle cnt", 32'(done_cnt), 2);
      chk("kept res_p", 32'(res_p), 6);

      // ---- reset during CALC
      do_reset();
      req = 4'b0001; a_in = 20'd3; b_in = 20'd7; res_ready = 1'b1;
      #1;
      chk("midrst gnt", 32'(gnt), 32'b0001);
      tick();
      req = 4'd0;
      chk("midrst in calc", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst busy", 32'(busy), 0);
      chk("midrst valid", 32'(res_valid), 0);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("midrst no valid", 32'(res_valid), 0);
      end
      chk("midrst cnt", 32'(done_cnt), 0);
      req = 4'b1111;
      #1;
      chk("midrst ptr gnt", 32'(gnt), 32'b0001);
      tick();
      req = 4'd0;
      tick();
      tick();

      // ---- exhaustive operand sweep on requester 2
      do_reset();
      res_ready = 1'b1;
      k = 0;
      for (int a = 0; a < 32; a++) begin
         for (int b = 0; b < 32; b++) begin
            req  = 4'b0100;
            a_in = 20'(a) << 10;
            b_in = 20'(b) << 10;
            tick();
            req = 4'd0;
            w = 0;
            while (res_valid !== 1'b1 && w < 4) begin
               tick();
               w++;
            end
            if (res_valid !== 1'b1) begin
               chk("sweep timeout", 32'(res_valid), 1);
            end else begin
               chk($sformatf("sweep %0d*%0d", a, b), 32'(res_p), 32'(a * b));
               chk("sweep res_id", 32'(res_id), 2);
            end
            tick();
            k++;
            if (k == 255) chk("cnt at 255", 32'(done_cnt), 255);
            if (k == 256) chk("cnt wrap", 32'(done_cnt), 0);
         end
      end
      chk("sweep final cnt", 32'(done_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
